signed_bcd_converter: RTL and testbench
=======================================

// Module: signed_bcd_converter
// PURPOSE
//  Sequential sign/magnitude to BCD converter. It sits directly downstream of the two's-complement
//  stage: it takes the unsigned magnitude that stage produces, plus the sign bit, and emits packed
//  BCD digits and a sign flag for the 7-segment display driver.
//  Conversion is iterative double-dabble (shift-add-3), one bit per clock.
// PARAMETERS
//  WIDTH   8  magnitude width in bits; covers the 0..128 range of an 8-bit signed operand.
//  DIGITS  3  number of BCD digits produced; must satisfy 10**DIGITS > 2**WIDTH-1.
// PORTS
//  clk      in   1          system clock, rising edge
//  rst_n    in   1          asynchronous reset, active-low
//  start    in   1          request a conversion; sampled only in IDLE
//  mag_in   in   WIDTH      unsigned magnitude from the two's-complement stage
//  neg_in   in   1          1 = the original operand was negative
//  busy     out  1          high while in SHIFT or FINISH
//  done     out  1          one-cycle pulse; bcd_out and neg_out are valid from this cycle
//  bcd_out  out  4*DIGITS   packed BCD result; digit 0 is in [3:0]
//  neg_out  out  1          sign of the result; forced to 0 when the magnitude is 0
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; busy=0, done=0, bcd_out=0, neg_out=0.
//   - The internal shift register and bit counter are cleared.
//   - Asserting reset mid-conversion aborts the conversion. No done pulse is issued.
//  FSM:
//   - IDLE   -> SHIFT  on start=1. mag_in/neg_in are latched, BCD scratch=0, bit counter=0.
//   - SHIFT  -> SHIFT  while counter < WIDTH-1. One double-dabble step per clock.
//   - SHIFT  -> FINISH after WIDTH steps.
//   - FINISH -> IDLE   unconditionally. bcd_out/neg_out are registered and done=1 for that cycle.
//  Double-dabble step (one per SHIFT clock):
//   - Each BCD nibble >= 5 gets +3, applied to all nibbles in parallel.
//   - Then the concatenation {bcd, bin} shifts left by 1; the binary MSB enters bcd bit 0.
//  Latency and timing:
//   - start sampled at edge 0; shifts occur on edges 1..WIDTH; outputs and done update at edge WIDTH+1.
//   - Total latency is WIDTH+1 clocks (9 at default).
//   - busy is decoded from the state register: high after edge 0, low after edge WIDTH+1.
//  Handshake and input rules:
//   - start while busy=1 is ignored. There is no queueing and latched operands are unaffected.
//   - start in the same cycle as done (state already IDLE) is accepted; back-to-back throughput
//     is one result per WIDTH+2 clocks.
//   - mag_in and neg_in may change freely after the start edge.
//  Output rules:
//   - bcd_out and neg_out hold their last value until the next FINISH; they never show partial values.
//   - Zero handling: mag_in=0 with neg_in=1 gives neg_out=0 (no negative zero).
//   - Full range: magnitude 2**WIDTH-1 (255 at default) converts to 12'h255; no overflow at legal parameters.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   - At FINISH, every zero nibble above the most significant non-zero digit is replaced by 4'hF
//     (blank code for the display driver).
//   - Digit 0 is never blanked.
//  LEADING_ZERO_BLANK_EN undefined:
//   - bcd_out is plain BCD with leading zeros as 4'h0.
//   - No blanking logic is synthesised.
// TESTING
//  1. mag_in=127, neg_in=0, start pulse -> busy for 9 clocks, done at edge 9, bcd_out=12'h127, neg_out=0.
//  2. mag_in=128, neg_in=1 -> bcd_out=12'h128, neg_out=1; mag_in=255 -> bcd_out=12'h255.
//  3. mag_in=0, neg_in=1 -> bcd_out=12'h000, neg_out=0.
//  4. start at edge 0 (mag 42), start again at edge 4 with mag 99
//     -> one done only, bcd_out=12'h042; start in the done cycle is accepted.
//  5. rst_n low at edge 5 of a conversion -> outputs 0 immediately, no done, busy=0.
//     After release, the next conversion is correct.
//  6. With LEADING_ZERO_BLANK_EN: mag 7 -> 12'hFF7; mag 0 -> 12'hFF0; mag 105 -> 12'h105.

Source files
------------

// File: rtl/signed_bcd_converter.sv
// Sequential sign/magnitude to packed-BCD converter using iterative double-dabble, one bit per clock.
// Optional build macro LEADING_ZERO_BLANK_EN replaces leading zero digits with the blank code 4'hF.
module signed_bcd_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      mag_in,
    input  logic                  neg_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state;
    logic [BCD_W-1:0]   bcd_q;
    logic [WIDTH-1:0]   bin_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_final;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Scan from the top digit down; digit 0 always shows, even when the value is zero.
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] value);
        logic [BCD_W-1:0] result;
        logic             leading;
        result  = value;
        leading = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (leading && (value[4*i +: 4] == 4'd0)) begin
                result[4*i +: 4] = 4'hF;
            end else begin
                leading = 1'b0;
            end
        end
        return result;
    endfunction

    assign bcd_final = blank_leading(bcd_q);
`else
    assign bcd_final = bcd_q;
`endif

    assign busy = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bcd_q   <= '0;
            bin_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            neg_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_q <= mag_in;
                        bcd_q <= '0;
                        cnt_q <= '0;
                        // A zero magnitude never carries a minus sign.
                        neg_q <= neg_in && (mag_in != '0);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
                    cnt_q          <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bcd_out <= bcd_final;
                    neg_out <= neg_q;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_bcd_converter.sv
// Directed self-checking bench for signed_bcd_converter: a vector table plus hand-written
// sequences for ignored start, back-to-back start, and mid-conversion reset.
module tb_signed_bcd_converter;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [WIDTH-1:0]    mag_in;
    logic                neg_in;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd_out;
    logic                neg_out;

    int n_vec;
    int n_err;

    typedef struct {
        logic [7:0]  mag;
        logic        neg;
        logic [11:0] bcd_plain;
        logic [11:0] bcd_blank;
        logic        neg_exp;
    } vec_t;

    vec_t vecs[10];

    signed_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mag_in  (mag_in),
        .neg_in  (neg_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .neg_out (neg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [11:0] pick(input vec_t v);
`ifdef LEADING_ZERO_BLANK_EN
        return v.bcd_blank;
`else
        return v.bcd_plain;
`endif
    endfunction

    // Present operands before the edge, then scramble them right after edge 0.
    task automatic start_conv(input logic [7:0] m, input logic n);
        @(negedge clk);
        mag_in = m;
        neg_in = n;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mag_in = ~m;
        neg_in = ~n;
    endtask

    // Entered 1 time unit after edge 0; returns 1 time unit after edge WIDTH+1.
    task automatic finish_conv(input string name, input logic [11:0] exp_bcd, input logic exp_neg);
        int          bad;
        logic [11:0] held;
        bad  = 0;
        held = bcd_out;
        for (int k = 0; k <= WIDTH; k++) begin
            if (busy !== 1'b1 || done !== 1'b0 || bcd_out !== held) bad++;
            @(posedge clk);
            #1;
        end
        check({name, "_busy_window"}, bad, 0);
        check({name, "_done"}, {31'd0, done}, 1);
        check({name, "_busy_low"}, {31'd0, busy}, 0);
        check({name, "_bcd"}, {20'd0, bcd_out}, {20'd0, exp_bcd});
        check({name, "_neg"}, {31'd0, neg_out}, {31'd0, exp_neg});
    endtask

    initial begin
        int ndone;
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        mag_in = '0;
        neg_in = 1'b0;

        vecs[0] = '{8'd127, 1'b0, 12'h127, 12'h127, 1'b0};
        vecs[1] = '{8'd128, 1'b1, 12'h128, 12'h128, 1'b1};
        vecs[2] = '{8'd255, 1'b0, 12'h255, 12'h255, 1'b0};
        vecs[3] = '{8'd0,   1'b1, 12'h000, 12'hFF0, 1'b0};
        vecs[4] = '{8'd7,   1'b0, 12'h007, 12'hFF7, 1'b0};
        vecs[5] = '{8'd105, 1'b1, 12'h105, 12'h105, 1'b1};
        vecs[6] = '{8'd99,  1'b0, 12'h099, 12'hF99, 1'b0};
        vecs[7] = '{8'd10,  1'b1, 12'h010, 12'hF10, 1'b1};
        vecs[8] = '{8'd200, 1'b1, 12'h200, 12'h200, 1'b1};
        vecs[9] = '{8'd1,   1'b1, 12'h001, 12'hFF1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_bcd", {20'd0, bcd_out}, 0);
        check("reset_neg", {31'd0, neg_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            start_conv(vecs[i].mag, vecs[i].neg);
            finish_conv($sformatf("vec%0d", i), pick(vecs[i]), vecs[i].neg_exp);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 0);
        end

        // Second start while busy is ignored; the first operands survive.
        start_conv(8'd42, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        mag_in = 8'd99;
        neg_in = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (done === 1'b1) ndone++;
            @(posedge clk);
            #1;
        end
        check("ignored_start_done_count", ndone, 1);
        check("ignored_start_bcd", {20'd0, bcd_out}, 32'h042);
        check("ignored_start_neg", {31'd0, neg_out}, 0);

        // Start issued in the done cycle is accepted immediately.
        start_conv(8'd13, 1'b1);
        finish_conv("b2b_first", 12'h013, 1'b1);
        start_conv(8'd99, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
        finish_conv("b2b_second", 12'hF99, 1'b1);
`else
        finish_conv("b2b_second", 12'h099, 1'b1);
`endif

        // Reset asserted mid-conversion clears outputs at once and suppresses done.
        start_conv(8'd255, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_bcd", {20'd0, bcd_out}, 0);
        check("abort_neg", {31'd0, neg_out}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        check("abort_no_done", ndone, 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_conv(8'd128, 1'b1);
        finish_conv("after_abort", 12'h128, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
